// File: rtl/digital_tube_pkg.sv
// Shared types and constants for the seven-segment tube scanner and its neighbours.
package digital_tube_pkg;

    // Segment code width and the all-segments-off code
    localparam int unsigned SEG_W     = 8;
    localparam logic [7:0]  SEG_BLANK = 8'h00;

    // Scanner top-level state
    typedef enum logic {
        SCAN  = 1'b0,
        BLANK = 1'b1
    } scan_state_t;

    // Mode codes presented on fun by the front-panel controller
    localparam int unsigned FUN_CLOCK     = 0;
    localparam int unsigned FUN_SET       = 1;
    localparam int unsigned FUN_ALARM     = 2;
    localparam int unsigned FUN_STOPWATCH = 3;

endpackage

// File: rtl/scan_prescaler.sv
// Free-running slot prescaler: counts 0..DIV-1, flags the last cycle of a slot
// and the leading dead-time window. Also used by the keypad scanner.
module scan_prescaler #(
    parameter int DIV  = 50000,
    parameter int DEAD = 500
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick,
    output logic dead
);

    localparam int PRE_W = (DIV > 2) ? $clog2(DIV) : 1;

    logic [PRE_W-1:0] pre_reg;

    assign tick = (pre_reg == PRE_W'(DIV - 1));
    assign dead = (pre_reg < PRE_W'(DEAD));

    // Slot counter; clr holds it at the start of a slot
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            pre_reg <= '0;
        end else if (tick) begin
            pre_reg <= '0;
        end else begin
            pre_reg <= pre_reg + 1'b1;
        end
    end

endmodule

// File: rtl/digital_tube_scan_mux.sv
// Time-multiplexed seven-segment scanner: picks one pre-decoded channel by fun,
// scans its digits one-hot with dead-time per slot and a blank after every mode change.
module digital_tube_scan_mux
    import digital_tube_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int NUM_CH     = 4,
    parameter int SEL_W      = 2,
    parameter int SCAN_DIV   = 50000,
    parameter int DEAD_CYC   = 500,
    parameter int BLANK_CYC  = 1000
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [SEL_W-1:0]                    fun,
    input  logic [NUM_CH*NUM_DIGITS*SEG_W-1:0]  codes,
    input  logic [NUM_CH*NUM_DIGITS-1:0]        dig_en,
    output logic [SEG_W-1:0]                    codeout,
    output logic [NUM_DIGITS-1:0]               seg,
    output logic                                frame_tick
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int BLK_W = (BLANK_CYC > 2) ? $clog2(BLANK_CYC) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLANK_CYC - 1);

    scan_state_t          state_reg, state_next;
    logic [IDX_W-1:0]     idx_reg, idx_next;
    logic [BLK_W-1:0]     blank_reg, blank_next;
    logic [SEL_W-1:0]     fun_q_reg, fun_q_next;
    logic [SEG_W-1:0]     code_reg, code_next;
    logic [NUM_DIGITS-1:0] seg_reg, seg_next;
    logic                 frame_reg, frame_next;

    logic                 mode_change;
    logic                 pre_clr;
    logic                 pre_tick;
    logic                 pre_dead;

    logic [NUM_DIGITS*SEG_W-1:0] chan_codes [NUM_CH];
    logic [NUM_DIGITS-1:0]       chan_en    [NUM_CH];
    logic [NUM_DIGITS*SEG_W-1:0] sel_codes;
    logic [NUM_DIGITS-1:0]       sel_en;
    logic                        ch_hit;

    // Unpack the flat channel buses into per-channel rows
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_chan
            assign chan_codes[gi] = codes[gi*NUM_DIGITS*SEG_W +: NUM_DIGITS*SEG_W];
            assign chan_en[gi]    = dig_en[gi*NUM_DIGITS +: NUM_DIGITS];
        end
    endgenerate

    scan_prescaler #(
        .DIV  (SCAN_DIV),
        .DEAD (DEAD_CYC)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (pre_clr),
        .tick  (pre_tick),
        .dead  (pre_dead)
    );

    assign mode_change = (fun != fun_q_reg);

    // Select the latched channel; an out-of-range mode selects nothing (ch_hit=0)
    always_comb begin
        ch_hit    = 1'b0;
        sel_codes = '0;
        sel_en    = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (fun_q_reg == SEL_W'(c)) begin
                ch_hit    = 1'b1;
                sel_codes = chan_codes[c];
                sel_en    = chan_en[c];
            end
        end
    end

    // Next-state: mode change overrides everything and restarts the blank
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        blank_next = blank_reg;
        fun_q_next = fun_q_reg;
        pre_clr    = 1'b0;
        if (mode_change) begin
            fun_q_next = fun;
            state_next = BLANK;
            blank_next = '0;
            idx_next   = '0;
            pre_clr    = 1'b1;
        end else begin
            case (state_reg)
                SCAN: begin
                    if (pre_tick) begin
                        idx_next = (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
                    end
                end
                BLANK: begin
                    pre_clr = 1'b1;
                    if (blank_reg == BLK_LAST) begin
                        state_next = SCAN;
                        idx_next   = '0;
                    end else begin
                        blank_next = blank_reg + 1'b1;
                    end
                end
                default: begin
                    state_next = SCAN;
                    idx_next   = '0;
                end
            endcase
        end
    end

    // Output decode from the current counters; registered below
    always_comb begin
        seg_next   = '0;
        code_next  = SEG_BLANK;
        frame_next = 1'b0;
        if (state_reg == SCAN && ch_hit) begin
            code_next = sel_codes[idx_reg*SEG_W +: SEG_W];
            if (!pre_dead && sel_en[idx_reg]) begin
                seg_next[idx_reg] = 1'b1;
            end
        end
        if (state_reg == SCAN && pre_tick && idx_reg == IDX_LAST && !mode_change) begin
            frame_next = 1'b1;
        end
    end

    // FSM and scan counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= SCAN;
            idx_reg   <= '0;
            blank_reg <= '0;
            fun_q_reg <= fun;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            blank_reg <= blank_next;
            fun_q_reg <= fun_q_next;
        end
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg_reg   <= '0;
            code_reg  <= SEG_BLANK;
            frame_reg <= 1'b0;
        end else begin
            seg_reg   <= seg_next;
            code_reg  <= code_next;
            frame_reg <= frame_next;
        end
    end

    assign seg        = seg_reg;
    assign codeout    = code_reg;
    assign frame_tick = frame_reg;

endmodule

// File: tb/tb_digital_tube_scan_mux.sv
// Scoreboard bench for digital_tube_scan_mux: a timeline model predicts every
// output cycle, a monitor compares the DUT against the queued predictions.
module tb_digital_tube_scan_mux;

    localparam int NUM_DIGITS = 4;
    localparam int NUM_CH     = 3;
    localparam int SEL_W      = 2;
    localparam int SCAN_DIV   = 4;
    localparam int DEAD_CYC   = 1;
    localparam int BLANK_CYC  = 3;

    logic                             clk;
    logic                             rst_n;
    logic [SEL_W-1:0]                 fun;
    logic [NUM_CH*NUM_DIGITS*8-1:0]   codes;
    logic [NUM_CH*NUM_DIGITS-1:0]     dig_en;
    logic [7:0]                       codeout;
    logic [NUM_DIGITS-1:0]            seg;
    logic                             frame_tick;

    typedef struct {
        logic [7:0]            code;
        logic [NUM_DIGITS-1:0] segv;
        logic                  tick;
        int                    cyc;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    bit   done  = 0;

    digital_tube_scan_mux #(
        .NUM_DIGITS (NUM_DIGITS),
        .NUM_CH     (NUM_CH),
        .SEL_W      (SEL_W),
        .SCAN_DIV   (SCAN_DIV),
        .DEAD_CYC   (DEAD_CYC),
        .BLANK_CYC  (BLANK_CYC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fun        (fun),
        .codes      (codes),
        .dig_en     (dig_en),
        .codeout    (codeout),
        .seg        (seg),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the display is a timeline. Scanning runs from an origin edge
    // (reset edge, or BLANK_CYC edges after the latest mode change); the digit and
    // position within the slot are plain arithmetic on the time since that origin.
    int edge_n   = 0;
    int origin   = 0;
    int m_fun_q  = 0;
    bit m_init   = 0;

    always @(posedge clk) begin
        exp_t e;
        int   prev, t, pos, slot, cur_fun;
        bit   in_scan, valid, changed;
        cur_fun = int'(fun);
        e.cyc = edge_n;
        if (!rst_n) begin
            e.code = 8'h00;
            e.segv = '0;
            e.tick = 1'b0;
            if (!m_init || m_fun_q != cur_fun)
                $display("txn cyc=%0d reset fun=%0d", edge_n, cur_fun);
            m_fun_q = cur_fun;
            origin  = edge_n;
            m_init  = 1;
            exp_q.push_back(e);
        end else if (m_init) begin
            prev    = edge_n - 1;
            in_scan = (prev >= origin);
            t       = prev - origin;
            pos     = in_scan ? (t % SCAN_DIV) : 0;
            slot    = in_scan ? ((t / SCAN_DIV) % NUM_DIGITS) : 0;
            valid   = (m_fun_q < NUM_CH);
            e.code  = 8'h00;
            e.segv  = '0;
            if (in_scan && valid) begin
                e.code = codes[(m_fun_q*NUM_DIGITS + slot)*8 +: 8];
                if (pos >= DEAD_CYC && dig_en[m_fun_q*NUM_DIGITS + slot])
                    e.segv = NUM_DIGITS'(1) << slot;
            end
            changed = (cur_fun != m_fun_q);
            e.tick  = in_scan && (pos == SCAN_DIV-1) && (slot == NUM_DIGITS-1) && !changed;
            exp_q.push_back(e);
            if (changed) begin
                $display("txn cyc=%0d mode %0d -> %0d", edge_n, m_fun_q, cur_fun);
                m_fun_q = cur_fun;
                origin  = edge_n + BLANK_CYC;
            end
        end
        edge_n++;
    end

    // Monitor: every clock the DUT presents a new output word
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (codeout !== e.code) begin
                bad++;
                $display("FAIL codeout cyc=%0d got=%02h want=%02h", e.cyc, codeout, e.code);
            end
            total++;
            if (seg !== e.segv) begin
                bad++;
                $display("FAIL seg cyc=%0d got=%b want=%b", e.cyc, seg, e.segv);
            end
            total++;
            if (frame_tick !== e.tick) begin
                bad++;
                $display("FAIL frame_tick cyc=%0d got=%b want=%b", e.cyc, frame_tick, e.tick);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n  = 1'b0;
        fun    = 2'd0;
        dig_en = '1;
        for (int c = 0; c < NUM_CH; c++)
            for (int d = 0; d < NUM_DIGITS; d++)
                codes[(c*NUM_DIGITS + d)*8 +: 8] = 8'(16*c + d);
        cyc(3);
        rst_n = 1'b1;
        cyc(40);

        // Mid-slot change 0 -> 2
        cyc(2);
        fun = 2'd2;
        cyc(30);

        // Back-to-back toggles 1 -> 2 -> 1
        fun = 2'd1;
        cyc(1);
        fun = 2'd2;
        cyc(1);
        fun = 2'd1;
        cyc(20);

        // Channel 0 digit 2 masked
        fun = 2'd0;
        cyc(20);
        dig_en[2] = 1'b0;
        cyc(40);
        dig_en[2] = 1'b1;

        // Out-of-range mode
        fun = 2'd3;
        cyc(50);

        // Reset during blank, then mid-slot
        fun = 2'd0;
        cyc(1);
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        cyc(6);
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        cyc(20);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 39) == 0)
                fun = SEL_W'($urandom_range(0, 3));
            if ($urandom_range(0, 4) == 0)
                codes[$urandom_range(0, NUM_CH*NUM_DIGITS-1)*8 +: 8] = 8'($urandom);
            if ($urandom_range(0, 14) == 0)
                dig_en[$urandom_range(0, NUM_CH*NUM_DIGITS-1)] ^= 1'b1;
            if ($urandom_range(0, 199) == 0)
                rst_n = 1'b0;
            else
                rst_n = 1'b1;
            cyc(1);
        end
        rst_n = 1'b1;
        cyc(4);

        if (total == 0) begin
            bad++;
            $display("FAIL no_checks got=%0d want=>0", total);
        end
        done = 1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
